// File: rtl/vga_timing_counter.sv
// vga_timing_counter: pixel-position generator for the VGA text pipeline.
// Divides CLK down to the pixel rate and produces the horizontal and vertical
// counters, the line/frame strobes, the active-video flag and the cursor blink.
module vga_timing_counter #(
    parameter int CLK_DIV      = 2,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [9:0] horiz_c,
    output logic [9:0] vert_c,
    output logic       pix_en,
    output logic       line_end,
    output logic       frame_end,
    output logic       active,
    output logic       blink
);

    // Parameter sanity: geometry must fit the 10-bit counters and the
    // porch/active sums must fit inside the totals.
    if (CLK_DIV < 1 || CLK_DIV > 15) begin : g_bad_clk_div
        $error("CLK_DIV must be in 1..15");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 63) begin : g_bad_blink
        $error("BLINK_FRAMES must be in 1..63");
    end
    if (H_TOTAL < 1 || H_TOTAL > 1024 || H_SYNC + H_BACK + H_ACTIVE > H_TOTAL) begin : g_bad_h
        $error("horizontal geometry does not fit H_TOTAL / 10-bit counter");
    end
    if (V_TOTAL < 1 || V_TOTAL > 1024 || V_SYNC + V_BACK + V_ACTIVE > V_TOTAL) begin : g_bad_v
        $error("vertical geometry does not fit V_TOTAL / 10-bit counter");
    end

    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_START    = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END      = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] V_START    = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END      = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

    logic [3:0] presc_reg;
    logic       pix_en_reg;
    logic [9:0] horiz_reg;
    logic [9:0] vert_reg;
    logic [5:0] frame_cnt_reg;
    logic       blink_reg;

    // Prescaler: pix_en is registered so it is a clean one-CLK strobe that
    // appears on the edge where the prescaler wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_reg  <= 4'd0;
            pix_en_reg <= 1'b0;
        end else begin
            presc_reg  <= (presc_reg == DIV_LAST) ? 4'd0 : presc_reg + 4'd1;
            pix_en_reg <= (presc_reg == DIV_LAST);
        end
    end

    // Raster counters: advance on the edge that samples pix_en high; vertical
    // steps only when horizontal wraps, so both reach 0 on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            horiz_reg <= 10'd0;
            vert_reg  <= 10'd0;
        end else if (pix_en_reg) begin
            if (horiz_reg == H_LAST) begin
                horiz_reg <= 10'd0;
                vert_reg  <= (vert_reg == V_LAST) ? 10'd0 : vert_reg + 10'd1;
            end else begin
                horiz_reg <= horiz_reg + 10'd1;
            end
        end
    end

    // Blink: count frames and flip the blink level each time the count wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_cnt_reg <= 6'd0;
            blink_reg     <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt_reg == BLINK_LAST) begin
                frame_cnt_reg <= 6'd0;
                blink_reg     <= ~blink_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 6'd1;
            end
        end
    end

    // Strobes and active flag decode registered state only, so they cannot
    // glitch within a CLK period; strobes are qualified by pix_en.
    always_comb begin
        line_end  = pix_en_reg && (horiz_reg == H_LAST);
        frame_end = line_end && (vert_reg == V_LAST);
        active    = (horiz_reg >= H_START) && (horiz_reg <= H_END) &&
                    (vert_reg >= V_START) && (vert_reg <= V_END);
    end

    assign horiz_c = horiz_reg;
    assign vert_c  = vert_reg;
    assign pix_en  = pix_en_reg;
    assign blink   = blink_reg;

endmodule

// File: tb/tb_vga_timing_counter.sv
// Directed bench for vga_timing_counter using a shrunken raster so whole
// frames fit in a short run. Geometry: 16 pixels x 10 lines,
// visible horiz 6..13, visible vert 3..7, blink half-period 2 frames.
// dut_a runs at CLK_DIV=2, dut_b at CLK_DIV=1; both share CLK and RST.
// For dut_a, after edge e (counted from reset release) the raster position is
// p = (e-1)/2 (integer), pix_en is high on even e; for dut_b p = e-1.
module tb_vga_timing_counter;

    logic       CLK;
    logic       RST;
    logic [9:0] a_horiz, a_vert, b_horiz, b_vert;
    logic       a_pix, a_line, a_frame, a_active, a_blink;
    logic       b_pix, b_line, b_frame, b_active, b_blink;

    int n_cmp;
    int n_err;
    int edge_n;
    int cnt_pix, cnt_act, cnt_line, cnt_frame, cnt_b_frame;

    vga_timing_counter #(
        .CLK_DIV(2), .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_TOTAL(16),
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(5), .V_TOTAL(10), .BLINK_FRAMES(2)
    ) dut_a (
        .CLK(CLK), .RST(RST), .horiz_c(a_horiz), .vert_c(a_vert),
        .pix_en(a_pix), .line_end(a_line), .frame_end(a_frame),
        .active(a_active), .blink(a_blink)
    );

    vga_timing_counter #(
        .CLK_DIV(1), .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_TOTAL(16),
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(5), .V_TOTAL(10), .BLINK_FRAMES(2)
    ) dut_b (
        .CLK(CLK), .RST(RST), .horiz_c(b_horiz), .vert_c(b_vert),
        .pix_en(b_pix), .line_end(b_line), .frame_end(b_frame),
        .active(b_active), .blink(b_blink)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to absolute edge number target, sampling 1 time unit after it.
    task automatic adv_to(input int target);
        while (edge_n < target) begin
            @(posedge CLK);
            #1;
            edge_n++;
        end
    endtask

    task automatic check_a(input string tag, input int h, input int v, input int pe,
                           input int le, input int fe, input int act);
        $display("edge %0d %s: a h=%0d v=%0d pix=%0d line=%0d frame=%0d act=%0d blink=%0d",
                 edge_n, tag, a_horiz, a_vert, a_pix, a_line, a_frame, a_active, a_blink);
        check({tag, ".horiz"},  32'(a_horiz), 32'(h));
        check({tag, ".vert"},   32'(a_vert),  32'(v));
        check({tag, ".pix_en"}, 32'(a_pix),   32'(pe));
        check({tag, ".line"},   32'(a_line),  32'(le));
        check({tag, ".frame"},  32'(a_frame), 32'(fe));
        check({tag, ".active"}, 32'(a_active), 32'(act));
    endtask

    task automatic check_all_zero(input string tag);
        $display("t=%0t %s: a h=%0d v=%0d blink=%0d / b h=%0d v=%0d blink=%0d",
                 $time, tag, a_horiz, a_vert, a_blink, b_horiz, b_vert, b_blink);
        check_a(tag, 0, 0, 0, 0, 0, 0);
        check({tag, ".a_blink"}, 32'(a_blink), 32'd0);
        check({tag, ".b_outs"},
              32'({b_horiz, b_vert, b_pix, b_line, b_frame, b_active, b_blink}), 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        edge_n = 0;
        RST    = 1'b0;

        // Asynchronous reset with no clock edge yet
        #2 RST = 1'b1;
        #1 check_all_zero("rst_async");
        repeat (2) @(posedge CLK);
        #1 check_all_zero("rst_held");

        // Release between edges; edges are counted from here
        RST = 1'b0;
        edge_n = 0;

        adv_to(1); check_a("rel_e1", 0, 0, 0, 0, 0, 0);
        check("rel_e1.b_pix", 32'(b_pix), 32'd1);
        check("rel_e1.b_horiz", 32'(b_horiz), 32'd0);
        adv_to(2); check_a("rel_e2", 0, 0, 1, 0, 0, 0);
        check("rel_e2.b_horiz", 32'(b_horiz), 32'd1);
        adv_to(3); check_a("rel_e3", 1, 0, 0, 0, 0, 0);
        adv_to(4); check_a("rel_e4", 1, 0, 1, 0, 0, 0);
        adv_to(5); check_a("rel_e5", 2, 0, 0, 0, 0, 0);

        // Line wrap at horiz 15, vert 0
        adv_to(31); check_a("line_pre",  15, 0, 0, 0, 0, 0);
        adv_to(32); check_a("line_end",  15, 0, 1, 1, 0, 0);
        adv_to(33); check_a("line_wrap", 0,  1, 0, 0, 0, 0);

        // Active window corners
        adv_to(77);  check_a("act_6_2",  6,  2, 0, 0, 0, 0);
        adv_to(107); check_a("act_5_3",  5,  3, 0, 0, 0, 0);
        adv_to(109); check_a("act_6_3",  6,  3, 0, 0, 0, 1);
        adv_to(251); check_a("act_13_7", 13, 7, 0, 0, 0, 1);
        adv_to(253); check_a("act_14_7", 14, 7, 0, 0, 0, 0);
        adv_to(283); check_a("act_13_8", 13, 8, 0, 0, 0, 0);

        // Frame wrap
        adv_to(319); check_a("frame_pre",  15, 9, 0, 0, 0, 0);
        adv_to(320); check_a("frame_end",  15, 9, 1, 1, 1, 0);
        check("frame_end.b_blink", 32'(b_blink), 32'd0);
        adv_to(321); check_a("frame_wrap", 0,  0, 0, 0, 0, 0);
        check("blink_b_rise1", 32'(b_blink), 32'd1);
        check("blink_a_low",   32'(a_blink), 32'd0);

        // Per-frame totals over one full frame of dut_a (edges 322..641)
        cnt_pix = 0; cnt_act = 0; cnt_line = 0; cnt_frame = 0; cnt_b_frame = 0;
        while (edge_n < 641) begin
            adv_to(edge_n + 1);
            if (a_pix)              cnt_pix++;
            if (a_pix && a_active)  cnt_act++;
            if (a_line)             cnt_line++;
            if (a_frame)            cnt_frame++;
            if (b_frame)            cnt_b_frame++;
        end
        $display("frame totals: pix=%0d active=%0d line=%0d frame=%0d b_frame=%0d",
                 cnt_pix, cnt_act, cnt_line, cnt_frame, cnt_b_frame);
        check("cnt_pix",     32'(cnt_pix),     32'd160);
        check("cnt_active",  32'(cnt_act),     32'd40);
        check("cnt_line",    32'(cnt_line),    32'd10);
        check("cnt_frame",   32'(cnt_frame),   32'd1);
        check("cnt_b_frame", 32'(cnt_b_frame), 32'd2);
        check("blink_a_rise", 32'(a_blink), 32'd1);
        check("blink_b_fall", 32'(b_blink), 32'd0);

        adv_to(960); check("blink_b_pre6",  32'(b_blink), 32'd0);
        adv_to(961); check("blink_b_rise6", 32'(b_blink), 32'd1);

        // Asynchronous reset mid-frame at dut_a position (10,5)
        adv_to(1141);
        check_a("mid_pre", 10, 5, 0, 0, 0, 1);
        check("mid_pre.a_blink", 32'(a_blink), 32'd1);
        check("mid_pre.b_blink", 32'(b_blink), 32'd1);
        #2 RST = 1'b1;
        #1 check_all_zero("mid_rst");
        @(posedge CLK);
        #2 check_all_zero("mid_rst_edge");
        RST = 1'b0;
        edge_n = 0;
        adv_to(1); check_a("rerel_e1", 0, 0, 0, 0, 0, 0);
        adv_to(2); check_a("rerel_e2", 0, 0, 1, 0, 0, 0);
        adv_to(3); check_a("rerel_e3", 1, 0, 0, 0, 0, 0);
        check("rerel_e3.a_blink", 32'(a_blink), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
